audiosystem_ram_reader: RTL and testbench

AUDIOSYSTEM_RAM_READER -- requirements
Module: audiosystem_ram_reader

---
 rtl/audiosystem_ram_reader.sv | 143 ++++++++++++++
 tb/tb_audiosystem_ram_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/audiosystem_ram_reader.sv
// Streams a block of stereo samples from RAM (1-cycle read latency) into a 2-deep FIFO feeding a valid/ready sink.
// Optional looping playback is compiled in with `define AUDIOSYSTEM_RAM_READER_LOOP_EN.
module audiosystem_ram_reader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    input  logic              loop,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] reload_addr;
    logic [ADDR_W:0]   total_r;
    logic [ADDR_W:0]   count_r;
    logic              in_flight;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        occ;
    logic              accept, pop, push, issue, last_issue, loop_en;

`ifdef AUDIOSYSTEM_RAM_READER_LOOP_EN
    logic [ADDR_W-1:0] base_r;
    logic              loop_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_r <= '0;
            loop_r <= 1'b0;
        end else if (state == IDLE && accept) begin
            base_r <= base_addr;
            loop_r <= loop;
        end
    end

    assign loop_en     = loop_r;
    assign reload_addr = base_r;
`else
    logic loop_unused;
    assign loop_unused = loop;
    assign loop_en     = 1'b0;
    assign reload_addr = '0;
`endif

    // Handshake: a sample moves when src_valid && src_ready on a rising edge;
    // src_data holds the FIFO head and cannot change until that sample is popped.
    assign accept     = start && !stop && (num_words != '0);
    assign pop        = (occ != 2'd0) && src_ready;
    assign push       = in_flight;
    assign last_issue = ((count_r + (ADDR_W+1)'(1)) == total_r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (accept) state_nx = RUN;
            RUN: begin
                if (stop) begin
                    state_nx = IDLE;
                // a popping sample frees its slot this cycle, so it does not count
                end else if (({1'b0, occ} + {2'b0, in_flight}) < (3'd2 + {2'b0, pop})) begin
                    issue = 1'b1;
                    if (last_issue && !loop_en) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (occ == 2'd0 && !in_flight) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr        <= '0;
            total_r     <= '0;
            count_r     <= '0;
            in_flight   <= 1'b0;
            occ         <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            if (state == IDLE && accept) begin
                addr    <= base_addr;
                total_r <= num_words;
                count_r <= '0;
            end else if (issue) begin
                addr    <= (last_issue && loop_en) ? reload_addr : addr + ADDR_W'(1);
                count_r <= last_issue ? '0 : count_r + (ADDR_W+1)'(1);
            end
            in_flight <= issue;
            if (stop && state != IDLE) begin
                occ    <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    fifo_mem[wr_ptr] <= ram_readdata;
                    wr_ptr           <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                occ <= occ + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    assign ram_address    = addr;
    assign ram_chipselect = issue;
    assign src_valid      = (occ != 2'd0);
    assign src_data       = fifo_mem[rd_ptr];
    assign busy           = (state != IDLE);
    assign state_dbg      = state;

endmodule

// File: tb/tb_audiosystem_ram_reader.sv
// Directed bench for audiosystem_ram_reader: RAM[n]=n model, expected-sample queue, timing and abort checks.
module tb_audiosystem_ram_reader;
  localparam int AW = 13;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, stop, loop, src_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic [AW-1:0] ram_address;
  logic          ram_chipselect;
  logic [W-1:0]  ram_readdata;
  logic [W-1:0]  src_data;
  logic          src_valid, busy, done;
  logic [1:0]    state_dbg;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int issued_tot, xfer_tot;
  int first_v, last_x, done_c;

  audiosystem_ram_reader #(.ADDR_W(AW), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .base_addr(base_addr), .num_words(num_words), .loop(loop),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_readdata(ram_readdata),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock and RAM model (one cycle read latency, RAM[n] = n)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_chipselect) ram_readdata <= 32'(ram_address);
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] base, input logic [AW:0] n, input logic lp);
    @(negedge clk);
    base_addr = base; num_words = n; loop = lp; start = 1'b1; src_ready = 1'b1;
  endtask

  // one playback to completion; exp_q must hold the expected samples
  task automatic play(input logic [AW-1:0] base, input logic [AW:0] n, input logic lp,
                      input bit toggle, input int restart_cyc,
                      output int fv, output int lx, output int dc);
    int xf;
    bit prev_stall;
    logic [W-1:0] prev_data;
    fv = 0; lx = 0; dc = 0; xf = 0; prev_stall = 0; prev_data = '0;
    issued_tot = 0; xfer_tot = 0;
    pulse_start(base, n, lp);
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_cyc);
      if (start) begin base_addr = 13'h0500; num_words = 14'd2; end
      src_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      if (cyc == 1) begin
        check("first_cs", ram_chipselect, 1);
        check("first_addr", ram_address, base);
      end
      if (prev_stall) begin
        check("stall_valid", src_valid, 1);
        check("stall_stable", src_data, prev_data);
      end
      if (src_valid && src_ready) begin
        if (fv == 0) fv = cyc;
        lx = cyc;
        xf++;
        if (exp_q.size() > 0) check("data", src_data, exp_q.pop_front());
        else check("extra_xfer", src_valid, 0);
      end
      check("outstanding_le2", 32'((issued_tot - xfer_tot) <= 2), 1);
      if (ram_chipselect) issued_tot++;
      if (src_valid && src_ready) xfer_tot++;
      prev_stall = src_valid && !src_ready;
      prev_data  = src_data;
      if (done) begin dc = cyc; break; end
    end
    if (dc == 0) check("done_timeout", 0, 1);
    check("xfer_count", xf, 32'(n));
    check("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk); #1;
    check("done_width", done, 0);
    check("idle_busy", busy, 0);
  endtask

  // playback aborted by stop after stop_after transfers
  task automatic play_abort(input logic [AW-1:0] base, input logic [AW:0] n, input logic lp, input int stop_after);
    int xf;
    xf = 0;
    pulse_start(base, n, lp);
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start = 1'b0; src_ready = 1'b1;
      #1;
      if (done) check("early_done", done, 0);
      if (src_valid && src_ready) begin
        xf++;
        if (exp_q.size() > 0) check("abort_data", src_data, exp_q.pop_front());
        else check("abort_extra", src_valid, 0);
      end
      if (xf == stop_after) break;
    end
    check("abort_reached", xf, stop_after);
    @(negedge clk);
    stop = 1'b1; src_ready = 1'b0;
    #1;
    check("stop_cs", ram_chipselect, 0);
    check("stop_done", done, 0);
    @(negedge clk);
    stop = 1'b0;
    #1;
    check("abort_valid", src_valid, 0);
    check("abort_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("abort_quiet", {29'b0, ram_chipselect, done, src_valid}, 0);
    end
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; src_ready = 1'b0;
    base_addr = '0; num_words = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_addr", ram_address, 0);
    check("rst_cs", ram_chipselect, 0);
    check("rst_valid", src_valid, 0);
    check("rst_data", src_data, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_state", state_dbg, 0);
    @(negedge clk); reset = 1'b0;

    // basic run with latency checks
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h10 + i);
    play(13'h010, 14'd4, 1'b0, 1'b0, 0, first_v, last_x, done_c);
    check("first_valid_cyc", first_v, 3);
    check("no_bubble", last_x - first_v + 1, 4);
    check("done_cyc", done_c, 7);

    // address wrap
    exp_q.push_back(32'h1FFE); exp_q.push_back(32'h1FFF);
    exp_q.push_back(32'h0000); exp_q.push_back(32'h0001);
    play(13'h1FFE, 14'd4, 1'b0, 1'b0, 0, first_v, last_x, done_c);

    // backpressure
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h40 + i);
    play(13'h040, 14'd8, 1'b0, 1'b1, 0, first_v, last_x, done_c);

    // start while running is ignored
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h30 + i);
    play(13'h030, 14'd4, 1'b0, 1'b0, 2, first_v, last_x, done_c);
    check("restart_done_cyc", done_c, 7);

    // abort after third transfer
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h20 + i);
    play_abort(13'h020, 14'd16, 1'b0, 3);

    // loop mode
`ifdef AUDIOSYSTEM_RAM_READER_LOOP_EN
    for (int i = 0; i < 7; i++) exp_q.push_back(32'h100 + (i % 3));
    play_abort(13'h100, 14'd3, 1'b1, 7);
`else
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + i);
    play(13'h100, 14'd3, 1'b1, 1'b0, 0, first_v, last_x, done_c);
    check("loop_off_done_cyc", done_c, 6);
`endif

    // start with zero words, then start together with stop
    pulse_start(13'h050, 14'd0, 1'b0);
    @(negedge clk); start = 1'b0; #1;
    check("zero_busy", busy, 0);
    check("zero_cs", ram_chipselect, 0);
    pulse_start(13'h050, 14'd4, 1'b0);
    stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0; #1;
    check("start_stop_busy", busy, 0);

    // asynchronous reset mid-run
    pulse_start(13'h060, 14'd16, 1'b0);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("arst_outs", {27'b0, ram_chipselect, src_valid, busy, done, 1'b0}, 0);
    check("arst_addr", ram_address, 0);
    check("arst_data", src_data, 0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 2; i++) exp_q.push_back(32'h70 + i);
    play(13'h070, 14'd2, 1'b0, 1'b0, 0, first_v, last_x, done_c);
    check("post_rst_done_cyc", done_c, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
